// File: rtl/puf_key_reader.sv
// rtl/puf_key_reader.sv - majority-voting reader for a 256-bit PUF response
//
// Purpose: enables the PUF generator, waits for it to settle, samples its
// response NUM_SAMPLES times, resolves every bit by majority vote and presents
// the stabilised key with a valid/ack handshake plus an unstable-bit count.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, challenge  key request (honoured in IDLE) and generator control value
//   busy              high whenever the FSM is not in IDLE
//   puf_enable        generator enable
//   puf_ctrl          generator control input (challenge latched at start)
//   puf_response      generator output
//   key_out           voted key
//   key_valid/key_ack key handshake
//   unstable_count    number of bits whose samples disagreed
module puf_key_reader #(
   parameter int WIDTH         = 256,
   parameter int NUM_SAMPLES   = 5,
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLE_GAP    = 2,
   localparam int CNT_W        = $clog2(NUM_SAMPLES + 1),
   localparam int UC_W         = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       challenge,
   output logic             busy,
   output logic             puf_enable,
   output logic [1:0]       puf_ctrl,
   input  logic [WIDTH-1:0] puf_response,
   output logic [WIDTH-1:0] key_out,
   output logic             key_valid,
   input  logic             key_ack,
   output logic [UC_W-1:0]  unstable_count
);

   // Timer reloads with SETTLE_CYCLES-1 or SAMPLE_GAP; this width holds both.
   localparam int TW = $clog2(SETTLE_CYCLES + SAMPLE_GAP + 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_SAMPLES / 2);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, RESOLVE, DONE} state_t;

   state_t           state;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] sample_idx;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] vote;
   logic [UC_W-1:0]  uc_next;

   // A bit is unstable when some but not all samples saw a one.
   always_comb begin
      vote    = '0;
      uc_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         vote[i] = (cnt[i] > HALF);
         if (cnt[i] != '0 && cnt[i] != FULL)
            uc_next = uc_next + UC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         timer          <= '0;
         sample_idx     <= '0;
         busy           <= 1'b0;
         puf_enable     <= 1'b0;
         puf_ctrl       <= 2'b00;
         key_out        <= '0;
         key_valid      <= 1'b0;
         unstable_count <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  puf_ctrl   <= challenge;
                  puf_enable <= 1'b1;
                  busy       <= 1'b1;
                  timer      <= TW'(SETTLE_CYCLES - 1);
                  sample_idx <= '0;
                  for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (timer == '0) begin
                  state <= SAMPLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            SAMPLE: begin
               // timer==0 marks a sampling cycle; the gap is counted down between them.
               if (timer == '0) begin
                  for (int i = 0; i < WIDTH; i++)
                     cnt[i] <= cnt[i] + CNT_W'(puf_response[i]);
                  if (sample_idx == LAST) begin
                     state <= RESOLVE;
                  end else begin
                     sample_idx <= sample_idx + CNT_W'(1);
                     timer      <= TW'(SAMPLE_GAP);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            RESOLVE: begin
               key_out        <= vote;
               unstable_count <= uc_next;
               puf_enable     <= 1'b0;
               key_valid      <= 1'b1;
               state          <= DONE;
            end
            DONE: begin
               if (key_ack) begin
                  key_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_key_reader.sv
// tb/tb_puf_key_reader.sv - directed testbench for puf_key_reader
module tb_puf_key_reader;

   localparam int W = 256;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;

   // default-parameter instance
   logic           start = 1'b0;
   logic [1:0]     challenge = 2'b00;
   logic           busy, puf_enable, key_valid;
   logic [1:0]     puf_ctrl;
   logic [W-1:0]   puf_response = '0;
   logic [W-1:0]   key_out;
   logic           key_ack = 1'b0;
   logic [8:0]     unstable_count;

   // single-sample instance
   logic           start_b = 1'b0;
   logic [1:0]     challenge_b = 2'b00;
   logic           busy_b, puf_enable_b, key_valid_b;
   logic [1:0]     puf_ctrl_b;
   logic [W-1:0]   puf_response_b = '0;
   logic [W-1:0]   key_out_b;
   logic           key_ack_b = 1'b0;
   logic [8:0]     unstable_count_b;

   int errors = 0;
   int checks = 0;

   localparam logic [W-1:0] P_A5 = {32{8'hA5}};

   always #5 clk = ~clk;

   puf_key_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
      .busy(busy), .puf_enable(puf_enable), .puf_ctrl(puf_ctrl),
      .puf_response(puf_response), .key_out(key_out), .key_valid(key_valid),
      .key_ack(key_ack), .unstable_count(unstable_count)
   );

   puf_key_reader #(.WIDTH(256), .NUM_SAMPLES(1), .SETTLE_CYCLES(1), .SAMPLE_GAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .challenge(challenge_b),
      .busy(busy_b), .puf_enable(puf_enable_b), .puf_ctrl(puf_ctrl_b),
      .puf_response(puf_response_b), .key_out(key_out_b), .key_valid(key_valid_b),
      .key_ack(key_ack_b), .unstable_count(unstable_count_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (puf_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", puf_enable); end
      checks++; if (puf_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", puf_ctrl); end
      checks++; if (key_out !== '0) begin errors++; $display("FAIL reset_key: got %h expected 0", key_out); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
      checks++; if (unstable_count !== 9'd0) begin errors++; $display("FAIL reset_unstable: got %0d expected 0", unstable_count); end
      rst_n = 1'b1;
      step();
   endtask

   // Stable 0xA5 pattern: checks ctrl/enable/valid timing cycle by cycle.
   task automatic test_basic();
      puf_response = P_A5;
      challenge = 2'b10;
      start = 1'b1;
      step();
      start = 1'b0;
      challenge = 2'b01;
      for (int c = 1; c <= 19; c++) begin
         checks++; if (puf_ctrl !== 2'b10) begin errors++; $display("FAIL basic_ctrl c=%0d: got %b expected 10", c, puf_ctrl); end
         checks++; if (puf_enable !== (c <= 18)) begin errors++; $display("FAIL basic_enable c=%0d: got %b expected %b", c, puf_enable, c <= 18); end
         checks++; if (key_valid !== (c == 19)) begin errors++; $display("FAIL basic_valid c=%0d: got %b expected %b", c, key_valid, c == 19); end
         if (c < 19) step();
      end
      checks++; if (key_out !== P_A5) begin errors++; $display("FAIL basic_key: got %h expected %h", key_out, P_A5); end
      checks++; if (unstable_count !== 9'd0) begin errors++; $display("FAIL basic_unstable: got %0d expected 0", unstable_count); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %b expected 0", key_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_ack_busy: got %b expected 0", busy); end
   endtask

   // Bit 0 toggles 1,0,1,0,1 and bit 255 goes 0,0,1,1,0 across the five samples
   // (sample j is taken in cycle 5+3j); then the key is held unacked for 10 cycles.
   task automatic test_unstable_and_hold();
      logic [4:0]   b0s;
      logic [4:0]   b255s;
      logic [W-1:0] expect_key;
      logic [W-1:0] r;
      int j;
      b0s = 5'b10101;
      b255s = 5'b01100;
      expect_key = P_A5;
      expect_key[255] = 1'b0;
      r = P_A5; r[0] = b0s[0]; r[255] = b255s[0];
      puf_response = r;
      challenge = 2'b01;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         j = (c < 5) ? 0 : (c - 5) / 3;
         if (j > 4) j = 4;
         r = P_A5; r[0] = b0s[j]; r[255] = b255s[j];
         puf_response = r;
         if (c < 19) step();
      end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL unstable_valid: got %b expected 1", key_valid); end
      checks++; if (key_out !== expect_key) begin errors++; $display("FAIL unstable_key: got %h expected %h", key_out, expect_key); end
      checks++; if (unstable_count !== 9'd2) begin errors++; $display("FAIL unstable_count: got %0d expected 2", unstable_count); end
      puf_response = ~P_A5;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL hold_valid k=%0d: got %b expected 1", k, key_valid); end
      end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL hold_ack_valid: got %b expected 0", key_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_ack_busy: got %b expected 0", busy); end
      checks++; if (key_out !== expect_key) begin errors++; $display("FAIL hold_key_kept: got %h expected %h", key_out, expect_key); end
      checks++; if (unstable_count !== 9'd2) begin errors++; $display("FAIL hold_unstable_kept: got %0d expected 2", unstable_count); end
   endtask

   // start in SAMPLE, key_ack in SETTLE, start+key_ack together in DONE: none restart.
   task automatic test_ignore();
      logic [W-1:0] pat;
      pat = {8{32'h3C5A_96F0}};
      puf_response = pat;
      challenge = 2'b00;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         key_ack = (c == 2);
         start = (c == 7);
         challenge = (c == 7) ? 2'b11 : 2'b00;
         if (c < 19) step();
      end
      key_ack = 1'b0; start = 1'b0;
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ignore_valid_timing: got %b expected 1", key_valid); end
      checks++; if (puf_ctrl !== 2'b00) begin errors++; $display("FAIL ignore_ctrl: got %b expected 00", puf_ctrl); end
      checks++; if (key_out !== pat) begin errors++; $display("FAIL ignore_key: got %h expected %h", key_out, pat); end
      start = 1'b1; key_ack = 1'b1; challenge = 2'b11;
      step();
      start = 1'b0; key_ack = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_busy: got %b expected 0", busy); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ignore_done_valid: got %b expected 0", key_valid); end
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart_busy: got %b expected 0", busy); end
      checks++; if (puf_enable !== 1'b0) begin errors++; $display("FAIL ignore_no_restart_enable: got %b expected 0", puf_enable); end
      checks++; if (puf_ctrl !== 2'b00) begin errors++; $display("FAIL ignore_no_restart_ctrl: got %b expected 00", puf_ctrl); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_fresh_start: got %b expected 1", busy); end
      checks++; if (puf_ctrl !== 2'b11) begin errors++; $display("FAIL ignore_fresh_ctrl: got %b expected 11", puf_ctrl); end
      for (int c = 2; c <= 19; c++) step();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ignore_fresh_valid: got %b expected 1", key_valid); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
   endtask

   // Reset in the middle of sampling, then a full run on a new pattern.
   task automatic test_reset_mid();
      logic [W-1:0] p1;
      logic [W-1:0] p2;
      p1 = {8{32'hFFFF_0000}};
      p2 = {8{32'h0F0F_1234}};
      puf_response = p1;
      challenge = 2'b01;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 8; c++) step();
      rst_n = 1'b0;
      #1;
      checks++; if (puf_enable !== 1'b0) begin errors++; $display("FAIL rstmid_enable: got %b expected 0", puf_enable); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", key_valid); end
      checks++; if (puf_ctrl !== 2'b00) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 00", puf_ctrl); end
      step();
      rst_n = 1'b1;
      step();
      puf_response = p2;
      challenge = 2'b10;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         if (c == 18) begin
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid: got %b expected 0", key_valid); end
         end
         if (c < 19) step();
      end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_after: got %b expected 1", key_valid); end
      checks++; if (key_out !== p2) begin errors++; $display("FAIL rstmid_key: got %h expected %h", key_out, p2); end
      checks++; if (unstable_count !== 9'd0) begin errors++; $display("FAIL rstmid_unstable: got %0d expected 0", unstable_count); end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
   endtask

   // NUM_SAMPLES=1, SETTLE_CYCLES=1, SAMPLE_GAP=0: sample in cycle 2, valid at T+4.
   task automatic test_single_sample();
      logic [W-1:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      puf_response_b = r;
      challenge_b = 2'b01;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) puf_response_b = ~r;
         checks++; if (key_valid_b !== (c == 4)) begin errors++; $display("FAIL single_valid c=%0d: got %b expected %b", c, key_valid_b, c == 4); end
         if (c < 4) step();
      end
      checks++; if (key_out_b !== r) begin errors++; $display("FAIL single_key: got %h expected %h", key_out_b, r); end
      checks++; if (unstable_count_b !== 9'd0) begin errors++; $display("FAIL single_unstable: got %0d expected 0", unstable_count_b); end
      checks++; if (puf_ctrl_b !== 2'b01) begin errors++; $display("FAIL single_ctrl: got %b expected 01", puf_ctrl_b); end
      checks++; if (puf_enable_b !== 1'b0) begin errors++; $display("FAIL single_enable: got %b expected 0", puf_enable_b); end
      key_ack_b = 1'b1;
      step();
      key_ack_b = 1'b0;
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL single_ack_busy: got %b expected 0", busy_b); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_unstable_and_hold();
      test_ignore();
      test_reset_mid();
      test_single_sample();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_key_reader.md
Name: puf_key_reader

Overview:
- Consumer side of the 256-bit PUF generator interface. Drives the generator's enable and 2-bit control input, and samples its 256-bit response several times.
- Resolves each bit by majority vote and presents a stabilised key with a valid/ack handshake.
- Reports how many bits were unstable across samples, for health monitoring by the root-of-trust controller.

Parameters:
- WIDTH, 256, response/key width in bits.
- NUM_SAMPLES, 5, number of response samples voted. Must be odd, 1..15.
- SETTLE_CYCLES, 4, cycles puf_enable is held high before the first sample. Must be ≥1.
- SAMPLE_GAP, 2, idle cycles between consecutive samples. May be 0.
- CNT_W, derived as clog2(NUM_SAMPLES+1), per-bit vote counter width.
- UC_W, derived as clog2(WIDTH+1), unstable_count width (9 for 256).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a key generation. Honoured only in IDLE.
- challenge  in  2  control value for the generator. Latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- puf_enable  out  1  drives the generator enable.
- puf_ctrl  out  2  drives the generator control_input.
- puf_response  in  WIDTH  generator output_signal.
- key_out  out  WIDTH  voted key.
- key_valid  out  1  key_out and unstable_count are valid.
- key_ack  in  1  consumer accepts the key.
- unstable_count  out  UC_W  number of bits whose samples disagreed.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, puf_enable=0, puf_ctrl=0, key_out=0, key_valid=0, unstable_count=0. All vote counters, sample index and timers cleared.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, RESOLVE, DONE.
- IDLE:
  - start=1 at edge T: latch challenge into puf_ctrl, set puf_enable=1, clear vote counters, go to SETTLE.
  - puf_enable and puf_ctrl become visible at T+1.
- SETTLE: lasts exactly SETTLE_CYCLES cycles (T+1..T+SETTLE_CYCLES), then SAMPLE. No sampling occurs.
- SAMPLE:
  - First sample in the first SAMPLE cycle, then one every SAMPLE_GAP+1 cycles.
  - Each sample adds puf_response[i] to counter[i] for all i.
  - puf_enable stays high throughout.
  - After sample NUM_SAMPLES, go to RESOLVE.
- RESOLVE (1 cycle):
  - key_out[i] = (counter[i] > NUM_SAMPLES/2).
  - unstable_count = number of i with 0 < counter[i] < NUM_SAMPLES.
  - puf_enable is cleared.
  - Go to DONE.
- DONE:
  - key_valid=1 and held until key_ack=1, then IDLE. key_valid=0 from the next cycle.
  - key_out and unstable_count keep their values after ack until the next RESOLVE.
- Latency: key_valid rises at T + SETTLE_CYCLES + (NUM_SAMPLES-1)*(SAMPLE_GAP+1) + 3. With defaults this is T+19.
- start outside IDLE is ignored, including start and key_ack asserted together in DONE. A new start is required in IDLE.
- key_ack outside DONE is ignored.
- challenge changes after acceptance have no effect on puf_ctrl until the next accepted start.
- NUM_SAMPLES=1: key_out equals the single sample and unstable_count is always 0.
- Reset asserted mid-operation: immediate return to reset values. puf_enable drops asynchronously and no partial key is presented.
- Counters cannot overflow: CNT_W holds NUM_SAMPLES.

Test Plan:
- Reset, then start=1 with challenge=2'b10 and a constant response 0xA5 repeated across 256 bits → puf_ctrl=2'b10 from T+1, puf_enable high T+1..T+18, key_valid at T+19, key_out equals the pattern, unstable_count=0.
- Response stable except bit 0, which toggles 1,0,1,0,1, and bit 255, which is 0,0,1,1,0 → key_out[0]=1, key_out[255]=0, unstable_count=2.
- Hold key_ack=0 for 10 cycles in DONE, then pulse it → key_valid stays high for the whole wait, low the cycle after ack, busy low and key_out unchanged.
- start pulsed during SAMPLE, and start with key_ack together in DONE → no restart; FSM returns to IDLE and requires a fresh start.
- rst_n pulsed low at T+8 mid-sampling → puf_enable, busy and key_valid are 0 immediately. A subsequent start produces a correct key with fresh counters.
- Parameter build NUM_SAMPLES=1, SAMPLE_GAP=0, SETTLE_CYCLES=1, random response → key_valid at T+4, key_out equals the sampled response, unstable_count=0.
